ibm1620_mem_cycle_timer: RTL and testbench

Downstream consumer of the master clock ring (5-trigger Johnson counter, phases A–J, one phase per 2 µs). Decodes ring trigger states into phase numbers and sequences one core-memory cycle per ring revolution. Generates MAR load, read drive, sense strobe, write drive and per-bit inhibit. Validates ring sequencing and aborts on a malformed ring.

---
 rtl/ibm1620_mem_cycle_timer_if.sv | 29 ++
 rtl/ibm1620_mem_cycle_timer.sv | 226 ++++++++++++++++++++++
 tb/tb_ibm1620_mem_cycle_timer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibm1620_mem_cycle_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : ibm1620_mem_cycle_timer_if
// Purpose  : CPU-side request/response bundle of the core-memory cycle timer.
// Revision : 1.0 - initial release
// ============================================================================
interface ibm1620_mem_cycle_timer_if #(
    parameter int DATA_W = 12
);
    logic              cycle_req;
    logic              cycle_wr;
    logic [DATA_W-1:0] wr_data;
    logic              cycle_ack;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              cycle_done;

    modport master (
        output cycle_req, cycle_wr, wr_data,
        input  cycle_ack, busy, rd_data, rd_valid, cycle_done
    );

    modport slave (
        input  cycle_req, cycle_wr, wr_data,
        output cycle_ack, busy, rd_data, rd_valid, cycle_done
    );
endinterface
`default_nettype wire

// File: rtl/ibm1620_mem_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : ibm1620_mem_cycle_timer
// Purpose  : Decodes the 5-trigger clock ring into phases A..J and sequences
//            one core-memory read/regenerate or write cycle per revolution.
// Revision : 1.0 - initial release
// ============================================================================
module ibm1620_mem_cycle_timer #(
    parameter int DATA_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             ring,
    input  logic [DATA_W-1:0]      sense_in,
    ibm1620_mem_cycle_timer_if.slave bus,
    output logic [3:0]             phase,
    output logic                   mar_load,
    output logic                   read_drive,
    output logic                   sense_strobe,
    output logic                   write_drive,
    output logic [DATA_W-1:0]      inhibit,
    output logic                   ring_err
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_FAULT  = 2'd2;

    localparam logic [3:0] c_PH_A = 4'd0;
    localparam logic [3:0] c_PH_B = 4'd1;
    localparam logic [3:0] c_PH_D = 4'd3;
    localparam logic [3:0] c_PH_E = 4'd4;
    localparam logic [3:0] c_PH_F = 4'd5;
    localparam logic [3:0] c_PH_H = 4'd7;
    localparam logic [3:0] c_PH_J = 4'd9;

    localparam logic [4:0] c_RING_J = 5'b10000;

    logic [4:0]        r_ring;
    logic [3:0]        r_phase;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [3:0]        w_dec;
    logic [3:0]        w_succ;
    logic [3:0]        w_ph;
    logic              w_legal;
    logic              w_event;
    logic              w_fault;
    logic              w_tick;
    logic              w_into_a;

    logic              w_ack_nxt;
    logic              w_done_nxt;
    logic              w_capture;
    logic              w_accept;
    logic              w_active;
    logic              w_mar_nxt;
    logic              w_read_nxt;
    logic              w_sense_nxt;
    logic              w_write_nxt;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_inhibit_nxt;

    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ack;
    logic              r_done;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_mar;
    logic              r_read;
    logic              r_sense;
    logic              r_write;
    logic [DATA_W-1:0] r_inhibit;
    logic              r_ring_err;

    always_comb begin
        w_dec   = r_phase;
        w_legal = 1'b1;
        case (r_ring)
            5'b00000: w_dec = 4'd0;
            5'b00001: w_dec = 4'd1;
            5'b00011: w_dec = 4'd2;
            5'b00111: w_dec = 4'd3;
            5'b01111: w_dec = 4'd4;
            5'b11111: w_dec = 4'd5;
            5'b11110: w_dec = 4'd6;
            5'b11100: w_dec = 4'd7;
            5'b11000: w_dec = 4'd8;
            5'b10000: w_dec = 4'd9;
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_succ   = (r_phase == c_PH_J) ? c_PH_A : r_phase + 4'd1;
    assign w_event  = w_legal && (w_dec != r_phase);
    assign w_fault  = !w_legal || (w_event && (w_dec != w_succ));
    assign w_tick   = w_event && !w_fault;
    assign w_into_a = w_tick && (w_dec == c_PH_A);
    assign w_ph     = w_tick ? w_dec : r_phase;

    // Reset parks the ring register on J so a stale code cannot look like a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring  <= c_RING_J;
            r_phase <= c_PH_J;
        end else begin
            r_ring <= ring;
            if (w_tick && (r_state != c_ST_FAULT)) begin
                r_phase <= w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fault) begin
                    w_state_nxt = c_ST_FAULT;
                end else if (w_into_a && bus.cycle_req) begin
                    w_state_nxt = c_ST_ACTIVE;
                    w_ack_nxt   = 1'b1;
                    w_accept    = 1'b1;
                end
            end
            c_ST_ACTIVE: begin
                if (w_fault) begin
                    w_state_nxt = c_ST_FAULT;
                end else if (w_into_a) begin
                    w_done_nxt = 1'b1;
                    if (bus.cycle_req) begin
                        w_ack_nxt = 1'b1;
                        w_accept  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_tick && (w_dec == c_PH_E)) begin
                    w_capture = 1'b1;
                end
            end
            c_ST_FAULT: begin
                w_state_nxt = c_ST_FAULT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Drives follow the phase the ring is entering, qualified by the next state.
    assign w_active      = (w_state_nxt == c_ST_ACTIVE);
    assign w_mar_nxt     = w_active && (w_ph == c_PH_A);
    assign w_read_nxt    = w_active && (w_ph >= c_PH_B) && (w_ph <= c_PH_D);
    assign w_sense_nxt   = w_active && (w_ph == c_PH_D);
    assign w_write_nxt   = w_active && (w_ph >= c_PH_F) && (w_ph <= c_PH_H);
    assign w_word        = r_wr ? r_wdata : r_rd_data;
    assign w_inhibit_nxt = w_write_nxt ? ~w_word : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_ack      <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_mar      <= 1'b0;
            r_read     <= 1'b0;
            r_sense    <= 1'b0;
            r_write    <= 1'b0;
            r_inhibit  <= '0;
            r_ring_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr <= bus.cycle_wr;
                if (bus.cycle_wr) begin
                    r_wdata <= bus.wr_data;
                end
            end
            if (w_capture) begin
                r_rd_data <= sense_in;
            end
            r_ack      <= w_ack_nxt;
            r_done     <= w_done_nxt;
            r_rd_valid <= w_capture;
            r_busy     <= w_active;
            r_mar      <= w_mar_nxt;
            r_read     <= w_read_nxt;
            r_sense    <= w_sense_nxt;
            r_write    <= w_write_nxt;
            r_inhibit  <= w_inhibit_nxt;
            r_ring_err <= r_ring_err | (w_state_nxt == c_ST_FAULT);
        end
    end

    assign bus.cycle_ack  = r_ack;
    assign bus.cycle_done = r_done;
    assign bus.busy       = r_busy;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign phase          = r_phase;
    assign mar_load       = r_mar;
    assign read_drive     = r_read;
    assign sense_strobe   = r_sense;
    assign write_drive    = r_write;
    assign inhibit        = r_inhibit;
    assign ring_err       = r_ring_err;

endmodule
`default_nettype wire

// File: tb/tb_ibm1620_mem_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibm1620_mem_cycle_timer
// Purpose  : Directed ring revolutions with a scoreboard of ack / read / done
//            events; each cycle's drive widths and inhibit word are summarised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibm1620_mem_cycle_timer;

    localparam int K_ACK  = 0;
    localparam int K_RDV  = 1;
    localparam int K_DONE = 2;

    localparam logic [4:0] RING [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                         5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

    typedef struct {
        int          kind;
        int          rd;
        int          ss;
        int          wr;
        int          ml;
        logic [11:0] val;
        bit          bad;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  ring;
    logic [11:0] sense_in;
    logic [3:0]  phase;
    logic        mar_load;
    logic        read_drive;
    logic        sense_strobe;
    logic        write_drive;
    logic [11:0] inhibit;
    logic        ring_err;

    ibm1620_mem_cycle_timer_if #(.DATA_W(12)) bus ();

    ibm1620_mem_cycle_timer #(.DATA_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .ring         (ring),
        .sense_in     (sense_in),
        .bus          (bus),
        .phase        (phase),
        .mar_load     (mar_load),
        .read_drive   (read_drive),
        .sense_strobe (sense_strobe),
        .write_drive  (write_drive),
        .inhibit      (inhibit),
        .ring_err     (ring_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q [$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          busy_watch = 0;
    int          busy_low = 0;
    int          c_rd, c_ss, c_wr, c_ml;
    logic [11:0] c_inh;
    bit          c_inh_seen, c_bad;

    task automatic push(input int kind, input int rd, input int ss, input int wr,
                        input int ml, input logic [11:0] val);
        exp_t e;
        e.kind = kind; e.rd = rd; e.ss = ss; e.wr = wr; e.ml = ml; e.val = val; e.bad = 1'b0;
        q.push_back(e);
    endtask

    // ack: mar_load must be high with it; coinc says cycle_done pulses on the same edge
    task automatic push_ack(input int coinc);
        push(K_ACK, 0, 0, coinc, 1, 12'h000);
    endtask

    task automatic push_rdv(input logic [11:0] data);
        push(K_RDV, 0, 0, 0, 0, data);
    endtask

    task automatic push_done(input int hold, input logic [11:0] inh);
        push(K_DONE, 3 * hold, hold, 3 * hold, hold, inh);
    endtask

    task automatic clear_counts();
        c_rd = 0; c_ss = 0; c_wr = 0; c_ml = 0;
        c_inh = 12'h000; c_inh_seen = 1'b0; c_bad = 1'b0;
    endtask

    task automatic observe(input int kind, input int rd, input int ss, input int wr,
                           input int ml, input logic [11:0] val, input bit bad);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d val=%h, expected no event", kind, val);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.rd != rd || e.ss != ss || e.wr != wr || e.ml != ml ||
                e.val !== val || e.bad != bad) begin
                n_err++;
                $display("FAIL scoreboard: got kind=%0d rd=%0d ss=%0d wr=%0d ml=%0d val=%h bad=%0d, expected kind=%0d rd=%0d ss=%0d wr=%0d ml=%0d val=%h bad=%0d",
                         kind, rd, ss, wr, ml, val, bad, e.kind, e.rd, e.ss, e.wr, e.ml, e.val, e.bad);
            end
        end
    endtask

    task automatic monitor();
        clear_counts();
        forever begin
            @(negedge clk);
            if (rst) begin
                clear_counts();
            end else begin
                if (bus.cycle_done) begin
                    observe(K_DONE, c_rd, c_ss, c_wr, c_ml, c_inh, c_bad);
                    clear_counts();
                end
                if (bus.cycle_ack)
                    observe(K_ACK, 0, 0, int'(bus.cycle_done), int'(mar_load), 12'h000, 1'b0);
                if (bus.rd_valid)
                    observe(K_RDV, 0, int'(sense_strobe), 0, 0, bus.rd_data, 1'b0);
                if (busy_watch && !bus.busy) busy_low++;
                if (read_drive)   c_rd++;
                if (sense_strobe) c_ss++;
                if (mar_load)     c_ml++;
                if (write_drive) begin
                    c_wr++;
                    if (!c_inh_seen) begin
                        c_inh = inhibit;
                        c_inh_seen = 1'b1;
                    end else if (inhibit !== c_inh) begin
                        c_bad = 1'b1;
                    end
                end else if (inhibit !== 12'h000) begin
                    c_bad = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {phase, bus.busy, bus.cycle_ack, bus.cycle_done, bus.rd_valid, mar_load,
                   read_drive, sense_strobe, write_drive, ring_err, inhibit, bus.rd_data},
            {4'd9, 33'd0});
    endtask

    task automatic put_ring(input logic [4:0] code, input int n);
        ring = code;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_phases(input int first, input int last, input int hold,
                              input bit drop_at_c, input bit raise_at_e);
        for (int p = first; p <= last; p++) begin
            if (drop_at_c && p == 2) bus.cycle_req = 1'b0;
            if (raise_at_e && p == 4) bus.cycle_req = 1'b1;
            put_ring(RING[p], hold);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        rst = 1'b1;
        ring = RING[9];
        sense_in = 12'h000;
        bus.cycle_req = 1'b0;
        bus.cycle_wr = 1'b0;
        bus.wr_data = 12'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset_state");
        @(negedge clk);

        // read/regenerate cycle
        sense_in = 12'hA5C; bus.cycle_wr = 1'b0; bus.cycle_req = 1'b1;
        push_ack(0); push_rdv(12'hA5C); push_done(2, 12'h5A3);
        run_phases(0, 9, 2, 1, 0);

        // write cycle
        bus.cycle_wr = 1'b1; bus.wr_data = 12'h0F0; sense_in = 12'hFFF; bus.cycle_req = 1'b1;
        push_ack(1); push_rdv(12'hFFF); push_done(2, 12'hF0F);
        run_phases(0, 9, 2, 1, 0);

        // request held across three revolutions
        bus.cycle_wr = 1'b0; sense_in = 12'h123; bus.cycle_req = 1'b1;
        push_ack(1); push_rdv(12'h123); push_done(2, 12'hEDC);
        put_ring(RING[0], 2);
        busy_watch = 1'b1;
        run_phases(1, 9, 2, 0, 0);
        sense_in = 12'h456;
        push_ack(1); push_rdv(12'h456); push_done(3, 12'hBA9);
        run_phases(0, 9, 3, 0, 0);
        sense_in = 12'h789;
        push_ack(1); push_rdv(12'h789); push_done(2, 12'h876);
        run_phases(0, 9, 2, 1, 0);
        busy_watch = 1'b0;
        chk("busy_continuous", busy_low, 0);

        // request raised at phase E waits for the next A
        sense_in = 12'h3C3;
        run_phases(0, 9, 2, 0, 1);
        chk("idle_until_next_a", {bus.busy, bus.cycle_ack}, 2'b00);
        push_ack(0); push_rdv(12'h3C3); push_done(2, 12'hC3C);
        run_phases(0, 9, 2, 1, 0);

        // ring jumps C -> E mid-cycle
        bus.cycle_req = 1'b1;
        push_ack(1);
        run_phases(0, 2, 2, 0, 0);
        put_ring(5'b01111, 2);
        chk("jump_ring_err", ring_err, 1'b1);
        chk("jump_outputs_clear", {bus.busy, mar_load, read_drive, sense_strobe, write_drive, inhibit}, 17'd0);
        run_phases(5, 9, 2, 0, 0);
        run_phases(0, 9, 2, 0, 0);
        chk("fault_sticky", {ring_err, bus.busy}, 2'b10);
        bus.cycle_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset_after_fault");

        // illegal ring code
        run_phases(0, 1, 2, 0, 0);
        put_ring(5'b00101, 2);
        chk("illegal_ring_err", ring_err, 1'b1);
        rst = 1'b1;
        put_ring(RING[9], 2);
        rst = 1'b0;
        chk_idle("reset_after_illegal");

        // reset during phase G of an active cycle
        bus.cycle_wr = 1'b0; sense_in = 12'h6B2; bus.cycle_req = 1'b1;
        push_ack(0); push_rdv(12'h6B2);
        run_phases(0, 5, 2, 1, 0);
        put_ring(RING[6], 2);
        chk("phase_g_drive", {phase, write_drive, bus.busy, inhibit}, {4'd6, 1'b1, 1'b1, 12'h94D});
        rst = 1'b1;
        @(negedge clk);
        chk_idle("reset_mid_cycle");
        run_phases(7, 9, 1, 0, 0);
        rst = 1'b0;
        put_ring(RING[9], 2);

        // one-clk phases, write cycle
        bus.cycle_wr = 1'b1; bus.wr_data = 12'h3A5; sense_in = 12'h000; bus.cycle_req = 1'b1;
        push_ack(0); push_rdv(12'h000); push_done(1, 12'hC5A);
        run_phases(0, 9, 1, 1, 0);
        put_ring(RING[0], 3);
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
